// File: rtl/best_hash_tracker_if.sv
// Report stream from the best-hash tracker to the host serializer: valid/ready with a {bits_off, candidate} record.
// The master drives valid and data; the slave drives ready.
interface best_hash_tracker_if #(
    parameter int CANDIDATE_WIDTH = 128
);
    logic                       valid;
    logic                       ready;
    logic [9:0]                 bits_off;
    logic [CANDIDATE_WIDTH-1:0] candidate;

    modport master (
        output valid,
        output bits_off,
        output candidate,
        input  ready
    );

    modport slave (
        input  valid,
        input  bits_off,
        input  candidate,
        output ready
    );
endinterface

// File: rtl/best_hash_tracker.sv
// Purpose: track the lowest bits-off result and its candidate, and queue every new-best record for the host.
// Latency: 1 cycle from the done rising edge to the best_* outputs and to a first-word fall-through report head.
// Backpressure: report_o.ready stalls the queue; a new best that finds the queue full is dropped and counted.
// Option: define BEST_HASH_TIE_REPORT_EN to also report results equal to the current best.
module best_hash_tracker #(
    parameter int CANDIDATE_WIDTH = 128,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [9:0]                 hash_bits_off_i,
    input  logic                       bits_off_done_i,
    input  logic [CANDIDATE_WIDTH-1:0] candidate_i,
    output logic [9:0]                 best_bits_off_o,
    output logic [CANDIDATE_WIDTH-1:0] best_candidate_o,
    output logic [7:0]                 drop_count_o,
    output logic [31:0]                hash_count_o,
    best_hash_tracker_if.master        report_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [9:0]    NO_BEST = 10'h3FF;

    typedef struct packed {
        logic [9:0]                 bits_off;
        logic [CANDIDATE_WIDTH-1:0] candidate;
    } rec_t;

    rec_t                       mem_q [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [9:0]                 best_q, best_d;
    logic [CANDIDATE_WIDTH-1:0] best_cand_q, best_cand_d;
    logic [7:0]                 drop_q, drop_d;
    logic [31:0]                hash_q, hash_d;
    logic                       done_q, done_d;

    logic evt;
    logic lower;
    logic push_req;
    logic push_ok;
    logic pop;
    logic empty;
    logic full;

    always_comb begin
        evt   = bits_off_done_i && !done_q && !clear_i;
        lower = hash_bits_off_i < best_q;
`ifdef BEST_HASH_TIE_REPORT_EN
        push_req = evt && (lower || ((hash_bits_off_i == best_q) && (hash_bits_off_i != NO_BEST)));
`else
        push_req = evt && lower;
`endif
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && report_o.ready;
        // A pop in the same cycle frees the slot, so a full queue can still accept.
        push_ok = push_req && (!full || pop);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        best_d      = best_q;
        best_cand_d = best_cand_q;
        drop_d      = drop_q;
        hash_d      = hash_q;
        done_d      = bits_off_done_i;

        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            best_d      = NO_BEST;
            best_cand_d = '0;
            drop_d      = '0;
            hash_d      = '0;
        end else begin
            if (evt) begin
                hash_d = hash_q + 32'd1;
            end
            if (evt && lower) begin
                best_d      = hash_bits_off_i;
                best_cand_d = candidate_i;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (push_req && !push_ok && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            best_q      <= NO_BEST;
            best_cand_q <= '0;
            drop_q      <= '0;
            hash_q      <= '0;
            done_q      <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            best_q      <= best_d;
            best_cand_q <= best_cand_d;
            drop_q      <= drop_d;
            hash_q      <= hash_d;
            done_q      <= done_d;
        end
    end

    // Storage is reset so the head reads zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{bits_off: hash_bits_off_i, candidate: candidate_i};
        end
    end

    assign best_bits_off_o    = best_q;
    assign best_candidate_o   = best_cand_q;
    assign drop_count_o       = drop_q;
    assign hash_count_o       = hash_q;
    assign report_o.valid     = !empty;
    assign report_o.bits_off  = mem_q[rd_ptr_q[AW-1:0]].bits_off;
    assign report_o.candidate = mem_q[rd_ptr_q[AW-1:0]].candidate;

endmodule
